// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI width default, mode and slave state types
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 8;
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;
  typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with one-clk rise/fall pulses
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_last <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_last;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_last;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder with single-entry tx holding register
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sck,
  input  logic                  i_cs,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_underrun,
  output logic                  o_aborted
);
  localparam int CW = $clog2(DATA_WIDTH);
  spi_slv_state_e         r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_tx_shift, r_hold, r_rx_data;
  logic [DATA_WIDTH-2:0]  r_rx_shift;
  logic                   r_hold_full, r_word_done, r_urun_pend;
  logic                   r_rx_valid, r_underrun, r_aborted;
  logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic                   w_mosi, w_active, w_load, w_accept, w_last_bit;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_active   = r_state == ACTIVE;
  assign w_accept   = i_tx_valid & ~r_hold_full;
  assign w_last_bit = r_bit_cnt == CW'(DATA_WIDTH - 1);
  // next word is loaded at frame start or on the fall that closes a completed word
  assign w_load     = (~w_active & w_cs_fall) | (w_active & ~w_cs_rise & w_sck_fall & r_word_done);
  always_comb begin
    w_state_next = r_state;
    w_state_next = w_active ? (w_cs_rise ? IDLE : ACTIVE) : (w_cs_fall ? ACTIVE : IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mosi_sync <= '0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_rx_data   <= '0;
      r_rx_shift  <= '0;
      r_hold_full <= 1'b0;
      r_word_done <= 1'b0;
      r_urun_pend <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_aborted   <= 1'b0;
      if (w_accept) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) r_hold_full <= 1'b0;
      // underrun is reported on the word's first rise so a trailing load at frame end stays silent
      if (w_load) begin
        r_tx_shift  <= r_hold_full ? r_hold : '0;
        r_urun_pend <= ~r_hold_full;
      end else if (w_active & w_sck_fall) r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (w_active & w_cs_rise) begin
        r_aborted   <= r_bit_cnt != '0;
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
        r_urun_pend <= 1'b0;
      end else if (w_active & w_sck_rise) begin
        r_rx_shift  <= {r_rx_shift[DATA_WIDTH-3:0], w_mosi};
        r_underrun  <= r_urun_pend;
        r_urun_pend <= 1'b0;
        r_bit_cnt   <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        r_word_done <= w_last_bit;
        if (w_last_bit) begin
          r_rx_data  <= {r_rx_shift, w_mosi};
          r_rx_valid <= 1'b1;
        end
      end else if (w_active & w_sck_fall) r_word_done <= 1'b0;
    end
  end
  assign o_miso     = w_active & r_tx_shift[DATA_WIDTH-1];
  assign o_miso_oe  = w_active;
  assign o_tx_ready = ~r_hold_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_underrun = r_underrun;
  assign o_aborted  = r_aborted;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench acting as SPI master against a word-level reference model
module tb_spi_slave;
  localparam int H = 6;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, underrun, aborted;
  logic [7:0] tx_data = '0, rx_data;
  logic       tx_valid = 1'b0;
  int         n_tests = 0, n_fail = 0;
  int         n_rxv = 0, n_urun = 0, n_abort = 0;
  int         exp_rxv = 0, exp_urun = 0, exp_abort = 0;
  logic [7:0] exp_rx = '0, hold_val = '0, exp_tx, got;
  bit         hold_full = 1'b0;
  logic [7:0] mw [4];
  always #5 clk = ~clk;
  spi_slave dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_underrun(underrun), .o_aborted(aborted)
  );
  always @(negedge clk) begin
    if (rx_valid) n_rxv++;
    if (underrun) n_urun++;
    if (aborted) n_abort++;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_tx(input logic [7:0] d);
    int t = 0;
    if (hold_full) return;
    while (!tx_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    hold_full = 1'b1;
    hold_val = d;
  endtask
  // one master word: mosi set before each rise, miso sampled just before the rise
  task automatic xfer_word(input logic [7:0] m, input int nbits, input bit ld,
                           input logic [7:0] ldv, output logic [7:0] s);
    s = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = m[i];
      tick(H);
      s[i] = miso;
      sck = 1'b1;
      if (ld && i == 4 && !hold_full) begin
        tx_data = ldv;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        hold_full = 1'b1;
        hold_val = ldv;
        tick(H - 1);
      end else tick(H);
      sck = 1'b0;
    end
  endtask
  task automatic do_frame(input int nw, input int last_bits, input bit ld, input logic [7:0] ldv);
    int bits;
    cs = 1'b0;
    tick(2);
    for (int w = 0; w < nw; w++) begin
      bits = (w == nw - 1) ? last_bits : 8;
      exp_tx = hold_full ? hold_val : 8'h00;
      if (!hold_full) exp_urun++;
      hold_full = 1'b0;
      xfer_word(mw[w], bits, ld && w == 0, ldv, got);
      if (w == 0) chk("miso_oe_active", 32'(miso_oe), 32'd1);
      if (bits == 8) begin
        chk("miso_word", 32'(got), 32'(exp_tx));
        exp_rx = mw[w];
        exp_rxv++;
      end
    end
    if (last_bits == 8) hold_full = 1'b0;
    else exp_abort++;
    tick(H);
    cs = 1'b1;
    tick(10);
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
    chk("rx_valid_count", 32'(n_rxv), 32'(exp_rxv));
    chk("underrun_count", 32'(n_urun), 32'(exp_urun));
    chk("aborted_count", 32'(n_abort), 32'(exp_abort));
    chk("tx_ready", 32'(tx_ready), 32'(!hold_full));
    chk("idle_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("idle_miso", {31'd0, miso}, 32'd0);
  endtask
  initial begin
    tick(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_pulses", {29'd0, rx_valid, underrun, aborted}, 32'd0);
    rst_n = 1'b1;
    tick(4);
    send_tx(8'h3C);
    mw[0] = 8'hA5;
    do_frame(1, 8, 1'b0, 8'h00);
    mw[0] = 8'h5A;
    do_frame(1, 8, 1'b0, 8'h00);
    send_tx(8'h81);
    mw[0] = 8'($urandom);
    mw[1] = 8'($urandom);
    do_frame(2, 8, 1'b1, 8'h7E);
    send_tx(8'($urandom));
    mw[0] = 8'($urandom);
    do_frame(1, 5, 1'b0, 8'h00);
    mw[0] = 8'hC3;
    do_frame(1, 8, 1'b0, 8'h00);
    send_tx(8'($urandom));
    cs = 1'b0;
    tick(2);
    hold_full = 1'b0;
    xfer_word(8'hFF, 3, 1'b0, 8'h00, got);
    mosi = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {27'd0, miso, miso_oe, rx_valid, underrun, aborted}, 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    exp_rx = '0;
    cs = 1'b1;
    mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    mw[0] = 8'h96;
    do_frame(1, 8, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      tick(H);
      chk("cs_high_oe", 32'(miso_oe), 32'd0);
      sck = 1'b0;
      tick(H);
    end
    chk("cs_high_rx_valid", 32'(n_rxv), 32'(exp_rxv));
    mw[0] = 8'($urandom);
    do_frame(1, 8, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) send_tx(8'($urandom));
      for (int w = 0; w < 4; w++) mw[w] = 8'($urandom);
      do_frame(int'($urandom_range(1, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8,
               1'($urandom_range(0, 1)), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
